// File: rtl/dsp48a1_mac_seq_if.sv
// dsp48a1_mac_seq_if: sample stream, coefficient write port, result strobe and
// the DSP48A1 slice connections of dsp48a1_mac_seq.
interface dsp48a1_mac_seq_if #(
    parameter int ADDR_W = 3
);
    logic                start;
    logic signed [17:0]  x_in;
    logic                x_valid;
    logic                x_ready;
    logic                coef_we;
    logic [ADDR_W-1:0]   coef_addr;
    logic signed [17:0]  coef_data;
    logic signed [17:0]  dsp_a;
    logic signed [17:0]  dsp_b;
    logic signed [17:0]  dsp_d;
    logic [7:0]          dsp_opmode;
    logic                dsp_ce;
    logic signed [47:0]  P;
    logic [47:0]         result;
    logic                result_valid;
    logic                busy;

    modport master (
        output start, x_in, x_valid, coef_we, coef_addr, coef_data, P,
        input  x_ready, dsp_a, dsp_b, dsp_d, dsp_opmode, dsp_ce, result, result_valid, busy
    );

    modport slave (
        input  start, x_in, x_valid, coef_we, coef_addr, coef_data, P,
        output x_ready, dsp_a, dsp_b, dsp_d, dsp_opmode, dsp_ce, result, result_valid, busy
    );
endinterface

// File: rtl/dsp48a1_mac_seq.sv
// dsp48a1_mac_seq: streams TAPS samples against stored coefficients through a DSP48A1
// slice and captures the accumulated 48-bit P as one dot product per job.
module dsp48a1_mac_seq #(
    parameter int TAPS   = 8,
    parameter int ADDR_W = 3,
    parameter int LAT    = 4
) (
    input logic              CLK,
    input logic              RST,
    dsp48a1_mac_seq_if.slave bus
);
    localparam int DW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  k;
    logic [DW-1:0]      dcnt;
    logic signed [17:0] coef [TAPS];
    logic               x_ready;
    logic               busy;
    logic               result_valid;
    logic [47:0]        result;
    logic               hs;

    always_ff @(posedge CLK or posedge RST)
        if (RST)
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        else if (bus.coef_we && 32'(bus.coef_addr) < TAPS)
            coef[bus.coef_addr] <= bus.coef_data;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state        <= IDLE;
            k            <= '0;
            dcnt         <= '0;
            x_ready      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else
            case (state)
                IDLE:
                    if (bus.start) begin
                        state   <= ISSUE;
                        k       <= '0;
                        x_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                ISSUE:
                    if (hs) begin
                        if (k == ADDR_W'(TAPS - 1)) begin
                            state   <= DRAIN;
                            dcnt    <= '0;
                            x_ready <= 1'b0;
                        end else
                            k <= k + 1'b1;
                    end
                DRAIN:
                    // P already holds the last tap's contribution on this edge
                    if (dcnt == DW'(LAT - 1)) begin
                        state        <= DONE;
                        result       <= bus.P;
                        result_valid <= 1'b1;
                    end else
                        dcnt <= dcnt + 1'b1;
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase

    assign hs               = x_ready && bus.x_valid;
    assign bus.x_ready      = x_ready;
    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.result       = result;
    // stalls drop CE so the whole slice pipeline freezes with its partial sum intact
    assign bus.dsp_ce       = hs || state == DRAIN;
    assign bus.dsp_a        = hs ? bus.x_in : '0;
    assign bus.dsp_b        = hs ? coef[k] : '0;
    assign bus.dsp_d        = '0;
    assign bus.dsp_opmode   = state == DRAIN ? 8'h09 : state == ISSUE ? (k == '0 ? 8'h01 : 8'h09) : 8'h00;
endmodule

// File: doc/dsp48a1_mac_seq.md
# dsp48a1_mac_seq

Control stage that sits directly upstream of the DSP48A1 slice and consumes the slice's P output. It accepts a stream of TAPS samples over a valid/ready handshake and pairs each sample with a stored coefficient. It drives the slice's A/B/D/OPMODE/CE inputs so the slice computes a TAPS-term dot product, then captures the 48-bit P result and presents it with a one-cycle valid strobe.

## Interface
- TAPS, 8: terms per dot product (2..256).
- ADDR_W, 3: coefficient address width, ceil(log2(TAPS)).
- LAT, 4: number of enabled slice clock edges from operand capture until P holds that operand's contribution. Must equal the slice's register configuration.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; honoured only in IDLE.
- x_in  in  18  signed sample.
- x_valid  in  1  sample valid.
- x_ready  out  1  sample accepted when x_valid && x_ready.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  ADDR_W  coefficient index.
- coef_data  in  18  signed coefficient.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_d  out  18  to slice D; constant 0.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_ce  out  1  common clock enable for all slice registers.
- P  in  48  slice P output.
- result  out  48  captured dot product.
- result_valid  out  1  one-cycle strobe.
- busy  out  1  high in any state other than IDLE.

## Operation
- Coefficient file: TAPS x 18 registers.
  - Written on the clock edge when coef_we is high; writes are allowed in any state.
  - Read is combinational. A write in the same cycle as a read of that address is not visible until the next cycle.
  - Cleared to 0 by RST.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - x_ready=0, dsp_ce=0.
  - start=1 moves to ISSUE and sets the tap counter k=0.
- ISSUE:
  - x_ready=1.
  - On a handshake: dsp_a=x_in, dsp_b=coef[k], dsp_ce=1, and k increments.
  - dsp_opmode=8'h01 (X=M, Z=0) when k==0. Otherwise dsp_opmode=8'h09 (X=M, Z=P, add, no preadder, carry 0).
  - Without a handshake: dsp_ce=0 so the whole slice pipeline freezes, and dsp_a/dsp_b=0.
  - After the handshake with k==TAPS-1, move to DRAIN and clear the drain counter.
- DRAIN:
  - Lasts exactly LAT cycles.
  - dsp_ce=1, dsp_a=dsp_b=0, dsp_opmode=8'h09, x_ready=0.
  - Zero products leave the accumulation unchanged.
  - On the edge ending the last DRAIN cycle: result<=P, move to DONE.
- DONE:
  - result_valid=1 for this single cycle, dsp_ce=0.
  - Unconditionally returns to IDLE.
  - result holds its value until the next capture.
- Arithmetic: signed 18x18 products summed in the slice's 48-bit P. This block performs no truncation, saturation or sign handling of its own.
- start outside IDLE is ignored. x_valid outside ISSUE is ignored.

## Timing
- Reset values:
  - state IDLE; k=0.
  - x_ready, dsp_ce, result_valid and busy all 0.
  - dsp_a, dsp_b, dsp_d and dsp_opmode all 0.
  - result 0; coefficients 0.
- RST mid-job: abandons the job immediately (asynchronously). No result_valid is produced, and result returns to 0. The slice's P is not cleared here; the next job's first tap (opmode 8'h01) discards it.
- start to x_ready: 1 cycle.
- Last sample handshake in cycle c0: DRAIN covers c1..cLAT, result_valid is high in cLAT+1.
- Minimum job length with no stalls: 1 (IDLE) + TAPS + LAT + 1 cycles.
- Back-to-back jobs: start may be asserted in the IDLE cycle right after DONE.
- Stall cycles (x_valid=0 in ISSUE) add latency one-for-one and have no effect on the result.
- dsp_a, dsp_b and dsp_opmode are combinational from state, k and x_in. The slice registers them.

## Test plan
The bench instantiates this block driving the team's DSP48A1 top, configured so its depth equals LAT=4.
- Coefficients 1..8, eight samples of 1, no stalls:
  - result=48'd36.
  - result_valid exactly 5 cycles after the 8th handshake.
  - dsp_opmode=8'h01 on the first issue and 8'h09 on the rest.
- Same job with x_valid toggling every other cycle:
  - result=36.
  - dsp_ce=0 on every stall cycle.
  - result_valid 5 cycles after the last handshake.
- All coefficients 18'h3FFFE (-2), samples 3: result=48'hFFFF_FFFF_FFD0 (-48).
- Two back-to-back jobs, first with result 36, second with all coefficients 0: second result=0, showing no carryover of P.
- RST asserted in ISSUE after 3 handshakes:
  - All outputs return to reset values in the same cycle.
  - No result_valid.
  - After reloading coefficients 1..8, a fresh job returns 36.
- start pulsed during ISSUE and DRAIN: ignored. Exactly one result_valid per accepted start, and busy stays 1 from ISSUE through DONE.
